// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS32 pipeline front end.
//   NOP_INSTR        - encoding of sll $0,$0,0, used to fill pipeline bubbles
//   RESET_PC_DEFAULT - default program counter after reset
//   WORD_BYTES       - bytes per instruction word (PC increment)
//   ifid_sel_e       - what the IF/ID register does on the next clock edge
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,  // capture fetched word and PC+4
        IFID_HOLD   = 2'd1,  // keep current content (stall)
        IFID_BUBBLE = 2'd2,  // squash after a redirect
        IFID_FAULT  = 2'd3   // bubble marked as coming from a faulting PC
    } ifid_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux for the fetch stage (purely combinational).
// Ports:
//   pc          in  32  current fetch PC
//   fault       in  1   current PC is misaligned or outside instruction memory
//   stall       in  1   hazard unit hold request
//   id_redirect in  1   jump resolved in ID, target id_target
//   ex_redirect in  1   taken branch resolved in EX, target ex_target
//   next_pc     out 32  PC value to load on the next edge
//   ifid_sel    out 2   action for the IF/ID register on the next edge
// Priority, highest first: ex_redirect > id_redirect > stall > fault > sequential.
import mips_pkg::*;

module pc_next_sel (
    input  logic [31:0] pc,
    input  logic        fault,
    input  logic        stall,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic [31:0] next_pc,
    output ifid_sel_e   ifid_sel
);

    always_comb begin
        next_pc  = pc;
        ifid_sel = IFID_LOAD;
        if (ex_redirect) begin
            // The EX branch belongs to an older instruction than the ID jump.
            next_pc  = ex_target;
            ifid_sel = IFID_BUBBLE;
        end else if (id_redirect) begin
            next_pc  = id_target;
            ifid_sel = IFID_BUBBLE;
        end else if (stall) begin
            next_pc  = pc;
            ifid_sel = IFID_HOLD;
        end else if (fault) begin
            // Park on the faulting PC until a redirect or reset arrives.
            next_pc  = pc;
            ifid_sel = IFID_FAULT;
        end else begin
            next_pc  = pc + WORD_BYTES;
            ifid_sel = IFID_LOAD;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the MIPS32 pipeline. Owns the PC, presents it to instruction
// memory, and registers the returned word into IF/ID.
// Parameters:
//   RESET_PC   PC value after reset
//   MEM_WORDS  instruction-memory depth in words; valid byte range 0..MEM_WORDS*4-4
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   imem_addr   out 32  byte address to instruction memory (always equals pc)
//   imem_instr  in  32  instruction word for imem_addr, same cycle
//   stall       in  1   hold PC and IF/ID
//   id_redirect in  1   jump from ID, target id_target
//   ex_redirect in  1   taken branch from EX, target ex_target
//   pc          out 32  current fetch PC
//   ifid_instr  out 32  registered instruction
//   ifid_pc4    out 32  registered PC+4 of that instruction
//   ifid_valid  out 1   IF/ID holds a real instruction
//   ifid_fault  out 1   IF/ID slot came from a faulting PC
import mips_pkg::*;

module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        id_redirect,
    input  logic [31:0] id_target,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        ifid_fault
);

    localparam logic [31:0] LAST_ADDR = 32'(MEM_WORDS * 4 - 4);

    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        fault;
    ifid_sel_e   ifid_sel;

    // Redirect targets are loaded unchecked; the fault shows up on the
    // following fetch cycle when that PC is evaluated here.
    assign fault    = (pc_q[1:0] != 2'b00) || (pc_q > LAST_ADDR);
    assign pc_plus4 = pc_q + WORD_BYTES;

    // Address comes straight from the PC register: no input-to-address path.
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    pc_next_sel u_sel (
        .pc          (pc_q),
        .fault       (fault),
        .stall       (stall),
        .id_redirect (id_redirect),
        .id_target   (id_target),
        .ex_redirect (ex_redirect),
        .ex_target   (ex_target),
        .next_pc     (next_pc),
        .ifid_sel    (ifid_sel)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc4   <= 32'h0;
            ifid_valid <= 1'b0;
            ifid_fault <= 1'b0;
        end else begin
            case (ifid_sel)
                IFID_LOAD: begin
                    ifid_instr <= imem_instr;
                    ifid_pc4   <= pc_plus4;
                    ifid_valid <= 1'b1;
                    ifid_fault <= 1'b0;
                end
                IFID_HOLD: begin
                    ifid_instr <= ifid_instr;
                    ifid_pc4   <= ifid_pc4;
                    ifid_valid <= ifid_valid;
                    ifid_fault <= ifid_fault;
                end
                IFID_BUBBLE: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_pc4   <= 32'h0;
                    ifid_valid <= 1'b0;
                    ifid_fault <= 1'b0;
                end
                default: begin  // IFID_FAULT: memory word ignored, may alias
                    ifid_instr <= NOP_INSTR;
                    ifid_pc4   <= 32'h0;
                    ifid_valid <= 1'b0;
                    ifid_fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

IF stage of the MIPS32 pipeline and the requesting end of the instruction-memory interface. Owns the program counter, drives the byte address into `instructionMemory`, captures the returned word into the IF/ID pipeline register, and applies stall, redirect (jump from ID, branch from EX) and fetch-fault rules. Sits between the hazard/branch logic and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `MEM_WORDS`, 256, instruction-memory depth in words; valid fetch range is `0 .. MEM_WORDS*4-4`.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_addr`  out  32  byte address to instruction memory; equals `pc`.
- `imem_instr`  in  32  instruction word; combinational return for `imem_addr`, same cycle.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `id_redirect`  in  1  jump/jr resolved in ID.
- `id_target`  in  32  target for `id_redirect`.
- `ex_redirect`  in  1  taken branch resolved in EX.
- `ex_target`  in  32  target for `ex_redirect`.
- `pc`  out  32  current fetch PC.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc4`  out  32  registered PC+4 of that instruction.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_fault`  out  1  IF/ID slot came from a faulting PC.

## Operation
- Fetch fault: `pc[1:0] != 0` or `pc > MEM_WORDS*4-4`.
- Next-PC priority, highest first: `reset` > `ex_redirect` > `id_redirect` > `stall` > fault > sequential.
  - `ex_redirect`: PC <= `ex_target`; IF/ID <= bubble. Wins over a simultaneous `id_redirect` (older instruction).
  - `id_redirect` (no `ex_redirect`): PC <= `id_target`; IF/ID <= bubble.
  - Redirect overrides `stall`: the stalled IF/ID content is discarded.
  - `stall` only: PC and all IF/ID outputs hold.
  - Fault (no redirect/stall): PC holds; IF/ID <= bubble with `ifid_fault`=1. Core stays parked until a redirect or reset.
  - Sequential: PC <= PC+4 (mod 2^32); `ifid_instr` <= `imem_instr`, `ifid_pc4` <= PC+4, `ifid_valid`=1, `ifid_fault`=0.
- Bubble: `ifid_instr`=32'h0000_0000 (sll $0,$0,0), `ifid_pc4`=0, `ifid_valid`=0, `ifid_fault`=0 unless set by fault rule.
- Redirect targets are not checked at load; fault is evaluated on the following fetch cycle.
- `imem_instr` is ignored whenever the PC is faulting (memory index may alias).

## Timing
- Reset (async assert, sync-release usage): `pc`=`RESET_PC`, `ifid_instr`=0, `ifid_pc4`=0, `ifid_valid`=0, `ifid_fault`=0.
- `imem_addr` is combinational from the PC register; no combinational path from any input to `imem_addr`.
- Latency: PC presented in cycle n -> instruction visible on `ifid_*` in cycle n+1.
- Redirect asserted in cycle n -> target on `pc` in cycle n+1, its instruction on `ifid_*` in cycle n+2; exactly one bubble from ID redirect, one IF/ID bubble from EX redirect (ID/EX squash is the hazard unit's job).
- `reset` mid-stall or mid-redirect: all state returns to reset values immediately, independent of `clk`.
- PC+4 from 32'hFFFF_FFFC wraps to 0; that PC is a fault for default `MEM_WORDS`.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR` (32'h0), default `RESET_PC`, word size constant (4).
- One combinational sub-module `pc_next_sel`: priority mux producing next PC and IF/ID-load/bubble/hold select from redirect, stall and fault inputs. PC and IF/ID registers live in `instruction_fetch`.

## Test plan
- Reset then 4 free-running cycles with memory words 0x20080001.. at 0,4,8,12 -> `pc` 0,4,8,12,16; `ifid_pc4` 4,8,12,16 with matching words, `ifid_valid`=1.
- `stall` high for 2 cycles at PC=8 -> `pc`=8 and IF/ID unchanged for both cycles, resume at 12.
- `id_redirect`=1 and `ex_redirect`=1 same cycle, targets 0x40 / 0x80 -> `pc`=0x80 next cycle, IF/ID bubble (`ifid_valid`=0, `ifid_instr`=0).
- `ex_redirect` with `stall` high, target 0x20 -> `pc`=0x20, IF/ID bubble, stall ignored.
- Redirect to 0x402 (misaligned) and separately to 0x400 (out of range, 256 words) -> `pc` held, `ifid_fault`=1, `ifid_valid`=0 every cycle until `id_redirect` to 0x10 recovers.
- Assert `reset` asynchronously mid-cycle at PC=0x1C -> outputs reach reset values before next `clk` edge; fetch restarts at `RESET_PC`.
